// File: rtl/ecg_sample_sequencer.sv
// ecg_sample_sequencer
//
// Paces ADC conversions for an ECG front end and streams the results into a
// display buffer. A programmable divider produces a sample tick. Each tick
// requests one conversion, waits for the ADC to answer, and writes the result
// at a circular buffer address.
//
// Ports
//   clk_in       system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   enable       1 = run acquisition, 0 = stop after the current conversion
//   period[29:0] sample interval in clk_in cycles (0 and 1 act as 2)
//   limit[12:0]  buffer depth (0 acts as 8192)
//   hold         1 = freeze the buffer (conversions continue, no writes)
//   clear_flags  pulse, clears overrun and timeout_err
//   adc_start    one-cycle conversion request
//   adc_done     conversion complete, only looked at while converting
//   adc_data     conversion result, valid with adc_done
//   wr_en        one-cycle buffer write strobe
//   wr_addr      buffer write address
//   wr_data      buffer write data
//   frame_done   one-cycle pulse after the write that wraps the address
//   overrun      sticky, a tick arrived while a conversion was in flight
//   timeout_err  sticky, the ADC did not answer within TIMEOUT cycles
//   busy         1 whenever the sequencer is not idle
module ecg_sample_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable,
    input  logic [29:0] period,
    input  logic [12:0] limit,
    input  logic        hold,
    input  logic        clear_flags,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [15:0] adc_data,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_done,
    output logic        overrun,
    output logic        timeout_err,
    output logic        busy
);

    // Timeout counter spans 0..TIMEOUT-1.
    localparam int unsigned TmoW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StStart,
        StConvert,
        StWrite
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] div_q, div_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] wr_data_q;
    logic        adc_start_q;
    logic        wr_en_q;
    logic        frame_done_q;
    logic        overrun_q;
    logic        timeout_err_q;
    logic        busy_q;

    logic [29:0] period_eff;
    logic [13:0] limit_eff;
    logic [13:0] last_addr;
    logic        tick;
    logic        do_write;
    logic        at_last;
    logic        past_last;
    logic        frame_set;
    logic        overrun_set;
    logic        timeout_set;

    assign period_eff = (period < 30'd2) ? 30'd2 : period;
    assign limit_eff  = (limit == 13'd0) ? 14'd8192 : {1'b0, limit};
    assign last_addr  = limit_eff - 14'd1;

    // Compare with >= so that shrinking period below the running count
    // still produces a tick instead of a 2^30-cycle wraparound.
    assign tick = enable && (state_q != StIdle) && (div_q >= period_eff - 30'd1);

    assign overrun_set = tick && (state_q inside {StStart, StConvert, StWrite});

    // A write is performed in WRITE only if the strobe was raised for it.
    assign do_write  = (state_q == StWrite) && wr_en_q;
    assign at_last   = ({1'b0, addr_q} == last_addr);
    // Limit lowered beneath the current address: wrap silently.
    assign past_last = ({1'b0, addr_q} > last_addr);
    assign frame_set = do_write && at_last;

    // Divider: held at 0 while idle or disabled, restarts after each tick.
    always_comb begin
        div_d = div_q + 30'd1;
        if (!enable || state_q == StIdle || tick) begin
            div_d = 30'd0;
        end
    end

    // Address sequencing.
    always_comb begin
        addr_d = addr_q;
        if (do_write) begin
            if (at_last || past_last) begin
                addr_d = 13'd0;
            end else begin
                addr_d = addr_q + 13'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        timeout_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWaitTick;
                end
            end
            StWaitTick: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StConvert;
                tmo_d   = '0;
            end
            StConvert: begin
                if (adc_done) begin
                    state_d = StWrite;
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = enable ? StWaitTick : StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWrite: begin
                state_d = enable ? StWaitTick : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= StIdle;
            div_q         <= 30'd0;
            tmo_q         <= '0;
            addr_q        <= 13'd0;
            wr_data_q     <= 16'd0;
            adc_start_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            if (state_q == StConvert && adc_done) begin
                wr_data_q <= adc_data;
            end
            // Outputs are registered from the next state so each one is a
            // clean Moore decode. The write strobe takes hold as seen on the
            // edge that enters WRITE, so the strobe is glitch-free for its
            // full cycle.
            adc_start_q   <= (state_d == StStart);
            wr_en_q       <= (state_d == StWrite) && !hold;
            frame_done_q  <= frame_set;
            busy_q        <= (state_d != StIdle);
            // Setting events take priority over clear_flags.
            overrun_q     <= overrun_set | (overrun_q & ~clear_flags);
            timeout_err_q <= timeout_set | (timeout_err_q & ~clear_flags);
        end
    end

    assign adc_start   = adc_start_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ecg_sample_sequencer.sv
// Directed testbench for ecg_sample_sequencer. Inputs change and outputs are
// sampled on the falling clock edge; a small ADC model answers each
// adc_start three cycles later.
module tb_ecg_sample_sequencer;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [29:0] period = 30'd10;
    logic [12:0] limit = 13'd4;
    logic        hold = 1'b0;
    logic        clear_flags = 1'b0;
    logic        adc_done = 1'b0;
    logic [15:0] adc_data = 16'd0;
    logic        adc_start;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        frame_done;
    logic        overrun;
    logic        timeout_err;
    logic        busy;

    ecg_sample_sequencer #(.TIMEOUT(255)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .limit       (limit),
        .hold        (hold),
        .clear_flags (clear_flags),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    int wr_count = 0;
    int start_count = 0;
    always @(posedge clk_in) begin
        cyc         <= cyc + 1;
        wr_count    <= wr_count + int'(wr_en);
        start_count <= start_count + int'(adc_start);
    end

    int passed = 0;
    int total = 0;

    // ADC model: answers 3 cycles after adc_start with adc_word.
    bit          adc_en = 1'b0;
    bit          adc_inc = 1'b1;
    logic [15:0] adc_word = 16'hA000;
    int          adc_cnt = 0;
    initial begin
        forever begin
            @(negedge clk_in);
            adc_done = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    adc_done = 1'b1;
                    adc_data = adc_word;
                    if (adc_inc) adc_word = adc_word + 16'd1;
                end
            end
            if (adc_start && adc_en) adc_cnt = 3;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_start(input int bound, output int s, output bit found);
        found = 1'b0;
        s = 0;
        for (int i = 0; i < bound && !found; i++) begin
            step(1);
            if (adc_start) begin
                found = 1'b1;
                s = cyc;
            end
        end
    endtask

    int          starts[16];
    int          wcyc[16];
    logic [12:0] waddr[16];
    logic [15:0] wdata[16];
    int          fcyc[16];
    int          ns, nw, nf, e, s, s1, s2, snap, snap2, hstarts;
    bit          found;
    int          exp_addr[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state
        step(3);
        check("rst_adc_start", adc_start, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 13'd0);
        check("rst_wr_data", wr_data, 16'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_busy", busy, 1'b0);

        // period=10, limit=4, ADC latency 3
        adc_en = 1'b1;
        adc_inc = 1'b1;
        adc_word = 16'hA000;
        reset = 1'b0;
        enable = 1'b1;
        e = cyc;
        ns = 0; nw = 0; nf = 0;
        for (int i = 0; i < 120 && nw < 5; i++) begin
            step(1);
            if (adc_start && ns < 16) begin starts[ns] = cyc; ns++; end
            if (wr_en && nw < 16) begin
                waddr[nw] = wr_addr; wdata[nw] = wr_data; wcyc[nw] = cyc; nw++;
            end
            if (frame_done && nf < 16) begin fcyc[nf] = cyc; nf++; end
        end
        for (int i = 0; i < 2; i++) begin
            step(1);
            if (frame_done && nf < 16) begin fcyc[nf] = cyc; nf++; end
        end
        check("write_count", nw, 5);
        check("first_start_latency", starts[0] - e, 11);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr_addr_%0d", i), waddr[i], exp_addr[i]);
            check($sformatf("wr_data_%0d", i), wdata[i], 16'hA000 + 16'(i));
            check($sformatf("start_to_write_%0d", i), wcyc[i] - starts[i], 4);
        end
        for (int i = 1; i < 5; i++) begin
            check($sformatf("start_spacing_%0d", i), starts[i] - starts[i-1], 10);
        end
        check("frame_done_count", nf, 1);
        check("frame_done_cycle", fcyc[0], wcyc[3] + 1);

        // Hold for 3 samples with data 0x1234
        hold = 1'b1;
        adc_inc = 1'b0;
        adc_word = 16'h1234;
        snap = wr_count;
        hstarts = 0;
        for (int i = 0; i < 100 && hstarts < 3; i++) begin
            step(1);
            if (adc_start) hstarts++;
        end
        step(6);
        check("hold_starts", hstarts, 3);
        check("hold_no_wr_en", wr_count - snap, 0);
        check("hold_addr_kept", wr_addr, 13'd1);
        check("hold_data_latched", wr_data, 16'h1234);
        hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1);
            if (wr_en) found = 1'b1;
        end
        check("release_write_seen", found, 1'b1);
        check("release_write_addr", wr_addr, 13'd1);
        check("release_write_data", wr_data, 16'h1234);
        step(1);
        check("release_addr_incr", wr_addr, 13'd2);

        // period=0 acts as 2: overrun, clear, set-wins
        reset = 1'b1; enable = 1'b0;
        step(2);
        period = 30'd0;
        adc_inc = 1'b1;
        reset = 1'b0; enable = 1'b1;
        wait_start(20, s1, found);
        check("ovr_start_found", found, 1'b1);
        step(4);
        check("ovr_set", overrun, 1'b1);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("ovr_cleared", overrun, 1'b0);
        step(3);
        check("ovr_reset_again", overrun, 1'b1);
        wait_start(20, s2, found);
        check("ovr_cadence", s2 - s1, 12);
        step(1);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("ovr_set_wins", overrun, 1'b1);

        // ADC never answers: timeout after 255 CONVERT cycles
        reset = 1'b1; enable = 1'b0;
        step(2);
        adc_en = 1'b0;
        period = 30'd400;
        reset = 1'b0; enable = 1'b1;
        snap = wr_count;
        wait_start(1000, s, found);
        check("tmo_start_found", found, 1'b1);
        step(255);
        check("tmo_not_yet", timeout_err, 1'b0);
        step(1);
        check("tmo_set", timeout_err, 1'b1);
        wait_start(1000, s2, found);
        check("tmo_next_start", s2 - s, 400);
        check("tmo_no_wr_en", wr_count - snap, 0);
        check("tmo_addr_kept", wr_addr, 13'd0);
        check("tmo_no_overrun", overrun, 1'b0);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("tmo_cleared", timeout_err, 1'b0);

        // Reset asserted mid-conversion
        reset = 1'b1; enable = 1'b0;
        step(2);
        adc_en = 1'b1;
        adc_word = 16'h5A5A;
        period = 30'd10;
        reset = 1'b0; enable = 1'b1;
        wait_start(30, s, found);
        check("rstc_start_found", found, 1'b1);
        step(1);
        reset = 1'b1;
        step(1);
        check("rstc_outputs_zero",
              {adc_start, wr_en, wr_addr, wr_data, frame_done, overrun, timeout_err, busy},
              35'd0);
        step(1);
        reset = 1'b0; enable = 1'b0;
        snap = wr_count;
        snap2 = start_count;
        step(12);
        check("rstc_no_write", wr_count - snap, 0);
        check("rstc_no_start", start_count - snap2, 0);
        check("rstc_idle", busy, 1'b0);
        check("rstc_data_zero", wr_data, 16'd0);

        // Enable dropped during CONVERT
        enable = 1'b1;
        wait_start(30, s, found);
        check("endrop_start_found", found, 1'b1);
        step(1);
        enable = 1'b0;
        step(3);
        check("endrop_wr_en", wr_en, 1'b1);
        check("endrop_busy_in_write", busy, 1'b1);
        step(1);
        check("endrop_busy_off", busy, 1'b0);
        snap2 = start_count;
        step(30);
        check("endrop_no_start", start_count - snap2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
